// File: rtl/vga_pkg.sv
// Shared display geometry defaults and direction indices for the character overlay blocks.
package vga_pkg;

    localparam int DEF_H_RES  = 640;
    localparam int DEF_V_RES  = 480;
    localparam int DEF_CHAR_W = 16;
    localparam int DEF_CHAR_H = 24;

    // Bit positions within the {Right, Left, Down, Up} request vector
    localparam int DIR_UP    = 0;
    localparam int DIR_DOWN  = 1;
    localparam int DIR_LEFT  = 2;
    localparam int DIR_RIGHT = 3;

endpackage

// File: rtl/axis_wrap_stepper.sv
// One-axis modular stepper: next start (+/- step mod RES), inclusive end and wrap flag.
// Purely combinational; the caller registers the results.
module axis_wrap_stepper #(
    parameter int RES = 640,
    parameter int W   = 10
) (
    input  logic [W-1:0] i_start,
    input  logic [W-1:0] i_size,
    input  logic [W-1:0] i_step,
    input  logic         i_inc,
    input  logic         i_dec,
    input  logic         i_load,
    output logic [W-1:0] o_next_start,
    output logic [W-1:0] o_end,
    output logic         o_wrap
);

    localparam logic [W:0] RES_W = (W+1)'(RES);
    localparam logic [W:0] ONE_W = (W+1)'(1);

    logic [W:0] w_start_x;
    logic [W:0] w_step_x;
    logic [W:0] w_size_x;
    logic [W:0] w_plus;
    logic [W-1:0] w_plus_mod;
    logic [W-1:0] w_minus_mod;
    logic [W:0] w_end_x;

    assign w_start_x = {1'b0, i_start};
    assign w_step_x  = {1'b0, i_step};
    assign w_size_x  = {1'b0, i_size};

    // Sums carry one extra bit so the modular correction sees the true value
    assign w_plus      = w_start_x + w_step_x;
    assign w_plus_mod  = (w_plus >= RES_W) ? W'(w_plus - RES_W) : W'(w_plus);
    assign w_minus_mod = (i_start < i_step) ? W'(w_start_x + RES_W - w_step_x)
                                            : W'(w_start_x - w_step_x);

    assign o_next_start = (i_load && i_inc) ? w_plus_mod  :
                          (i_load && i_dec) ? w_minus_mod : i_start;

    assign w_end_x = {1'b0, o_next_start} + w_size_x - ONE_W;
    assign o_end   = (w_end_x >= RES_W) ? W'(w_end_x - RES_W) : W'(w_end_x);
    assign o_wrap  = (o_end < o_next_start);

endmodule

// File: rtl/char_position_ctrl.sv
// Character bounding-box position: edge-detected direction/size requests are held and applied at frameStart.
// Outputs registered, updated the cycle after frameStart; moved pulses one cycle when anything changed.
module char_position_ctrl
    import vga_pkg::*;
#(
    parameter int H_RES  = DEF_H_RES,
    parameter int V_RES  = DEF_V_RES,
    parameter int CHAR_W = DEF_CHAR_W,
    parameter int CHAR_H = DEF_CHAR_H,
    parameter int HW     = $clog2(H_RES),
    parameter int VW     = $clog2(V_RES)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [1:0]    charSize,
    input  logic [3:0]    OffsetFlag,
    input  logic          frameStart,
    output logic [HW-1:0] posHorStart,
    output logic [HW-1:0] posHorEnd,
    output logic [VW-1:0] posVerStart,
    output logic [VW-1:0] posVerEnd,
    output logic          hWrap,
    output logic          vWrap,
    output logic          moved
);

    if (4*CHAR_W > H_RES || 4*CHAR_H > V_RES) begin : g_size_chk
        $error("char_position_ctrl: largest character box exceeds the screen");
    end

    logic [1:0]    r_scale;
    logic [3:0]    r_flag_q;
    logic [3:0]    r_pending;
    logic          r_size_pend;
    logic [HW-1:0] r_hstart, r_hend;
    logic [VW-1:0] r_vstart, r_vend;
    logic          r_hwrap, r_vwrap, r_moved;

    logic [3:0]    w_req, w_eff;
    logic          w_apply;
    logic [1:0]    w_scale_nxt;
    logic [2:0]    w_mult;
    logic [HW-1:0] w_hsize, w_hcentre, w_hbase, w_hnext, w_hend;
    logic [VW-1:0] w_vsize, w_vcentre, w_vbase, w_vnext, w_vend;
    logic          w_hwrap, w_vwrap, w_changed;

    assign w_req   = OffsetFlag & ~r_flag_q;
    assign w_eff   = r_pending | w_req;
    assign w_apply = frameStart & ~reset;

    assign w_scale_nxt = (reset || r_size_pend || (charSize != r_scale)) ? charSize : r_scale;
    assign w_mult      = {1'b0, w_scale_nxt} + 3'd1;

    assign w_hsize   = HW'(CHAR_W * int'(w_mult));
    assign w_vsize   = VW'(CHAR_H * int'(w_mult));
    assign w_hcentre = HW'((H_RES - CHAR_W * int'(w_mult)) / 2);
    assign w_vcentre = VW'((V_RES - CHAR_H * int'(w_mult)) / 2);

    // Reset reuses the steppers with no motion so the ends come out of the same path
    assign w_hbase = reset ? w_hcentre : r_hstart;
    assign w_vbase = reset ? w_vcentre : r_vstart;

    axis_wrap_stepper #(.RES(H_RES), .W(HW)) u_hor (
        .i_start      (w_hbase),
        .i_size       (w_hsize),
        .i_step       (w_hsize),
        .i_inc        (w_eff[DIR_RIGHT] & ~w_eff[DIR_LEFT]),
        .i_dec        (w_eff[DIR_LEFT]  & ~w_eff[DIR_RIGHT]),
        .i_load       (w_apply),
        .o_next_start (w_hnext),
        .o_end        (w_hend),
        .o_wrap       (w_hwrap)
    );

    axis_wrap_stepper #(.RES(V_RES), .W(VW)) u_ver (
        .i_start      (w_vbase),
        .i_size       (w_vsize),
        .i_step       (w_vsize),
        .i_inc        (w_eff[DIR_DOWN] & ~w_eff[DIR_UP]),
        .i_dec        (w_eff[DIR_UP]   & ~w_eff[DIR_DOWN]),
        .i_load       (w_apply),
        .o_next_start (w_vnext),
        .o_end        (w_vend),
        .o_wrap       (w_vwrap)
    );

    assign w_changed = {w_hnext, w_hend, w_hwrap, w_vnext, w_vend, w_vwrap} !=
                       {r_hstart, r_hend, r_hwrap, r_vstart, r_vend, r_vwrap};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_scale     <= charSize;
            r_flag_q    <= 4'b1111;
            r_pending   <= 4'b0000;
            r_size_pend <= 1'b0;
            r_moved     <= 1'b0;
            r_hstart    <= w_hnext;
            r_hend      <= w_hend;
            r_hwrap     <= w_hwrap;
            r_vstart    <= w_vnext;
            r_vend      <= w_vend;
            r_vwrap     <= w_vwrap;
        end else begin
            r_flag_q <= OffsetFlag;
            if (frameStart) begin
                r_scale     <= w_scale_nxt;
                r_pending   <= 4'b0000;
                r_size_pend <= 1'b0;
                r_moved     <= w_changed;
                r_hstart    <= w_hnext;
                r_hend      <= w_hend;
                r_hwrap     <= w_hwrap;
                r_vstart    <= w_vnext;
                r_vend      <= w_vend;
                r_vwrap     <= w_vwrap;
            end else begin
                r_pending   <= r_pending | w_req;
                r_size_pend <= r_size_pend | (charSize != r_scale);
                r_moved     <= 1'b0;
            end
        end
    end

    assign posHorStart = r_hstart;
    assign posHorEnd   = r_hend;
    assign posVerStart = r_vstart;
    assign posVerEnd   = r_vend;
    assign hWrap       = r_hwrap;
    assign vWrap       = r_vwrap;
    assign moved       = r_moved;

endmodule

// File: tb/tb_char_position_ctrl.sv
// Bench for char_position_ctrl: directed test-plan scenarios plus random traffic against a modular-arithmetic model.
module tb_char_position_ctrl;

    localparam int HR = 640;
    localparam int VR = 480;
    localparam int CW = 16;
    localparam int CH = 24;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] charSize = 2'd0;
    logic [3:0] OffsetFlag = 4'd0;
    logic       frameStart = 1'b0;
    logic [9:0] posHorStart, posHorEnd;
    logic [8:0] posVerStart, posVerEnd;
    logic       hWrap, vWrap, moved;

    int n_vec = 0;
    int n_err = 0;

    // Reference state
    int       m_hs, m_vs, m_scale;
    bit [3:0] m_pend, m_fq;
    bit       m_moved;

    char_position_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .charSize    (charSize),
        .OffsetFlag  (OffsetFlag),
        .frameStart  (frameStart),
        .posHorStart (posHorStart),
        .posHorEnd   (posHorEnd),
        .posVerStart (posVerStart),
        .posVerEnd   (posVerEnd),
        .hWrap       (hWrap),
        .vWrap       (vWrap),
        .moved       (moved)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: observed %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic int m_w();  return CW * (m_scale + 1); endfunction
    function automatic int m_h();  return CH * (m_scale + 1); endfunction
    function automatic int m_he(); return (m_hs + m_w() - 1) % HR; endfunction
    function automatic int m_ve(); return (m_vs + m_h() - 1) % VR; endfunction

    function automatic void model_clock();
        bit [3:0] req, eff;
        int old_hs, old_he, old_vs, old_ve;
        if (reset) begin
            m_scale = int'(charSize);
            m_hs = (HR - m_w()) / 2;
            m_vs = (VR - m_h()) / 2;
            m_pend = 4'd0;
            m_fq = 4'hF;
            m_moved = 1'b0;
        end else begin
            req = OffsetFlag & ~m_fq;
            m_fq = OffsetFlag;
            if (frameStart) begin
                old_hs = m_hs; old_he = m_he(); old_vs = m_vs; old_ve = m_ve();
                eff = m_pend | req;
                m_scale = int'(charSize);
                if (eff[3] && !eff[2]) m_hs = (m_hs + m_w()) % HR;
                if (eff[2] && !eff[3]) m_hs = (m_hs - m_w() + HR) % HR;
                if (eff[1] && !eff[0]) m_vs = (m_vs + m_h()) % VR;
                if (eff[0] && !eff[1]) m_vs = (m_vs - m_h() + VR) % VR;
                m_pend = 4'd0;
                m_moved = (old_hs != m_hs) || (old_he != m_he()) ||
                          (old_vs != m_vs) || (old_ve != m_ve());
            end else begin
                m_pend = m_pend | req;
                m_moved = 1'b0;
            end
        end
    endfunction

    task automatic compare_all();
        chk("hs",    int'(posHorStart), m_hs);
        chk("he",    int'(posHorEnd),   m_he());
        chk("vs",    int'(posVerStart), m_vs);
        chk("ve",    int'(posVerEnd),   m_ve());
        chk("hwrap", int'(hWrap),       int'(m_he() < m_hs));
        chk("vwrap", int'(vWrap),       int'(m_ve() < m_vs));
        chk("moved", int'(moved),       int'(m_moved));
    endtask

    task automatic cyc();
        @(posedge clk);
        model_clock();
        #1;
        compare_all();
    endtask

    task automatic press(input int dir);
        OffsetFlag[dir] = 1'b1; cyc();
        OffsetFlag[dir] = 1'b0; cyc();
    endtask

    task automatic frame();
        frameStart = 1'b1; cyc();
        frameStart = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1; cyc();
        reset = 1'b0; cyc();
    endtask

    initial begin
        reset = 1'b1;
        cyc();
        chk("rst_hs", int'(posHorStart), 312);
        chk("rst_he", int'(posHorEnd),   327);
        chk("rst_vs", int'(posVerStart), 228);
        chk("rst_ve", int'(posVerEnd),   251);
        chk("rst_wrap", int'({hWrap, vWrap}), 0);
        chk("rst_moved", int'(moved), 0);
        reset = 1'b0;
        cyc();

        for (int i = 1; i <= 20; i++) begin
            press(2);
            frame();
            chk("left_moved", int'(moved), 1);
            if (i == 19) chk("left19_hs", int'(posHorStart), 8);
            cyc();
        end
        chk("left20_hs", int'(posHorStart), 632);
        chk("left20_he", int'(posHorEnd), 7);
        chk("left20_wrap", int'(hWrap), 1);

        for (int i = 1; i <= 10; i++) begin
            press(0);
            frame();
            cyc();
        end
        chk("up10_vs", int'(posVerStart), 468);
        chk("up10_ve", int'(posVerEnd), 11);
        chk("up10_wrap", int'(vWrap), 1);

        do_reset();
        press(3); press(3); press(3);
        frame();
        chk("r3_hs", int'(posHorStart), 328);
        chk("r3_moved", int'(moved), 1);
        cyc();
        chk("r3_moved_end", int'(moved), 0);
        OffsetFlag = 4'b1100; cyc();
        OffsetFlag = 4'b0000; cyc();
        frame();
        chk("lr_hs", int'(posHorStart), 328);
        chk("lr_moved", int'(moved), 0);

        do_reset();
        charSize = 2'd1;
        repeat (4) cyc();
        chk("sz_hold_he", int'(posHorEnd), 327);
        frame();
        chk("sz_he", int'(posHorEnd), 343);
        chk("sz_ve", int'(posVerEnd), 275);
        chk("sz_hs", int'(posHorStart), 312);
        chk("sz_vs", int'(posVerStart), 228);
        chk("sz_moved", int'(moved), 1);

        charSize = 2'd0;
        OffsetFlag = 4'b1000;
        reset = 1'b1; cyc();
        reset = 1'b0; cyc(); cyc();
        frame();
        chk("held_hs", int'(posHorStart), 312);
        chk("held_moved", int'(moved), 0);
        OffsetFlag = 4'b0000; cyc();

        press(1);
        reset = 1'b1; frameStart = 1'b1; cyc();
        reset = 1'b0; frameStart = 1'b0; cyc();
        chk("rstfs_vs", int'(posVerStart), 228);
        frame();
        chk("rstfs_vs2", int'(posVerStart), 228);
        chk("rstfs_moved", int'(moved), 0);

        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 5) == 0) OffsetFlag[$urandom_range(0, 3)] ^= 1'b1;
            frameStart = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 149) == 0) charSize = 2'($urandom_range(0, 3));
            reset = ($urandom_range(0, 599) == 0);
            cyc();
        end
        reset = 1'b0;
        frameStart = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
